read_responder: RTL and testbench

- Serving end of the thread read-return interface: accepts per-thread read requests, issues them to a fixed-latency memory port, and emits one `read_return_t` per completed read.
- Its `data_return` output is the stream the thread scheduler consumes, so it must present at most one valid return per cycle and never back-pressure that output.
- Sits between the thread execution units (request side) and the local data memory.

---
 rtl/read_responder.sv | 113 +++++++++++
 tb/tb_read_responder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/read_responder.sv
// Read-return server: queues per-thread read requests, issues them to a fixed-latency
// memory port in FIFO order and emits one read_return_t per completed read.

typedef logic [4:0]  thread_id_t;
typedef logic [31:0] rd_data_t;

typedef struct packed {
   logic       valid;
   thread_id_t receive_id;
   rd_data_t   data;
   logic [1:0] status;
} read_return_t;

module read_responder #(
   parameter int DEPTH       = 4,
   parameter int ADDR_W      = 16,
   parameter int MEM_LATENCY = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   halt,
   input  logic                   req_valid,
   input  thread_id_t             req_id,
   input  logic [ADDR_W-1:0]      req_addr,
   output logic                   req_ready,
   output logic                   mem_rd_en,
   output logic [ADDR_W-1:0]      mem_addr,
   input  rd_data_t               mem_rd_data,
   output read_return_t           data_return,
   output logic [$clog2(DEPTH):0] pending_count,
   output logic                   idle
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0]      addr_mem [DEPTH];
   thread_id_t             id_mem   [DEPTH];
   logic [PTR_W-1:0]       wr_ptr_reg;
   logic [PTR_W-1:0]       rd_ptr_reg;
   logic [CNT_W-1:0]       count_reg;
   thread_id_t             issue_id_reg;
   logic [MEM_LATENCY-1:0] tag_valid_reg;
   thread_id_t             tag_id_reg [MEM_LATENCY];
   logic                   push;
   logic                   pop;

   // Readiness comes from the registered count only, so a same-cycle pop never frees a slot.
   assign req_ready     = (count_reg < CNT_W'(DEPTH));
   assign push          = req_valid && req_ready;
   assign pop           = (count_reg != '0) && !halt;
   assign pending_count = count_reg;
   assign idle          = (count_reg == '0) && (tag_valid_reg == '0) &&
                          !mem_rd_en && !data_return.valid;

   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr_reg] <= req_addr;
         id_mem[wr_ptr_reg]   <= req_id;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         mem_rd_en    <= 1'b0;
         mem_addr     <= '0;
         issue_id_reg <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         mem_rd_en <= pop;
         if (pop) begin
            rd_ptr_reg   <= rd_ptr_reg + 1'b1;
            mem_addr     <= addr_mem[rd_ptr_reg];
            issue_id_reg <= id_mem[rd_ptr_reg];
         end
         if (push && !pop) begin
            count_reg <= count_reg + 1'b1;
         end else if (pop && !push) begin
            count_reg <= count_reg - 1'b1;
         end
      end
   end

   // Tag pipeline tracks each strobe until its data arrives, then builds the return word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_valid_reg <= '0;
         for (int i = 0; i < MEM_LATENCY; i++) begin
            tag_id_reg[i] <= '0;
         end
         data_return <= '0;
      end else begin
         tag_valid_reg[0] <= mem_rd_en;
         tag_id_reg[0]    <= issue_id_reg;
         for (int i = 1; i < MEM_LATENCY; i++) begin
            tag_valid_reg[i] <= tag_valid_reg[i-1];
            tag_id_reg[i]    <= tag_id_reg[i-1];
         end
         data_return <= '0;
         if (tag_valid_reg[MEM_LATENCY-1]) begin
            data_return.valid      <= 1'b1;
            data_return.receive_id <= tag_id_reg[MEM_LATENCY-1];
            data_return.data       <= mem_rd_data;
         end
      end
   end

endmodule

// File: tb/tb_read_responder.sv
// Directed bench for read_responder: bench-side memory model, scoreboard queue of
// expected returns, and immediate-assertion checks at each comparison point.

module tb_read_responder;

   logic        clk;
   logic        rst_n;
   logic        halt;
   logic        req_valid;
   logic [4:0]  req_id;
   logic [15:0] req_addr;
   logic        req_ready;
   logic        mem_rd_en;
   logic [15:0] mem_addr;
   logic [31:0] mem_rd_data;
   logic [39:0] data_return;
   logic [2:0]  pending_count;
   logic        idle;

   int checks    = 0;
   int failures  = 0;
   int ret_total = 0;
   int run_len   = 0;
   int cyc       = 0;
   int last_ret  = -10;

   logic [39:0] sb [$];

   read_responder #(.DEPTH(4), .ADDR_W(16), .MEM_LATENCY(2)) dut (
      .clk(clk), .rst_n(rst_n), .halt(halt),
      .req_valid(req_valid), .req_id(req_id), .req_addr(req_addr), .req_ready(req_ready),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
      .data_return(data_return), .pending_count(pending_count), .idle(idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_fn(input logic [15:0] a);
      if (a == 16'h0010) return 32'h0000_DEAD;
      return {a ^ 16'h5A5A, a};
   endfunction

   // Memory model: data for a strobe appears two cycles later; noise otherwise.
   logic        d1_v, d2_v;
   logic [15:0] d1_a, d2_a;
   logic [31:0] noise;
   initial begin
      d1_v = 1'b0; d2_v = 1'b0; d1_a = '0; d2_a = '0; noise = '0;
   end
   always @(posedge clk) begin
      d1_v  <= mem_rd_en;
      d1_a  <= mem_addr;
      d2_v  <= d1_v;
      d2_a  <= d1_a;
      noise <= $urandom;
      cyc   <= cyc + 1;
   end
   assign mem_rd_data = d2_v ? mem_fn(d2_a) : noise;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (data_return[39]) begin
         ret_total++;
         run_len  = (last_ret == cyc - 1) ? run_len + 1 : 1;
         last_ret = cyc;
         if (sb.size() == 0) begin
            chk("unexpected_return", data_return, 40'h0);
         end else begin
            logic [39:0] exp;
            exp = sb.pop_front();
            $display("return id=%0d data=%h exp_id=%0d exp_data=%h", data_return[38:34],
                     data_return[33:2], exp[38:34], exp[33:2]);
            chk("return_word", data_return, exp);
         end
      end else begin
         chk("return_cleared", data_return, 40'h0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [4:0] id, input logic [15:0] a);
      int  n;
      logic acc;
      n = 0;
      acc = 1'b0;
      req_valid = 1'b1;
      req_id    = id;
      req_addr  = a;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = req_ready;
         step();
         n++;
      end
      req_valid = 1'b0;
      chk("send_accept", acc, 1'b1);
      if (acc) sb.push_back({1'b1, id, mem_fn(a), 2'b00});
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!idle && n < 200) begin
         step();
         n++;
      end
      chk("idle_reached", idle, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      rst_n = 1'b0; halt = 1'b0; req_valid = 1'b0; req_id = '0; req_addr = '0;
      repeat (2) step();
      chk("rst_mem_rd_en", mem_rd_en, 1'b0);
      chk("rst_mem_addr", mem_addr, 16'h0);
      chk("rst_data_return", data_return, 40'h0);
      chk("rst_req_ready", req_ready, 1'b1);
      chk("rst_pending", pending_count, 3'd0);
      chk("rst_idle", idle, 1'b1);
      rst_n = 1'b1;
      step();

      // Single request latency: accept T, strobe T+2, return T+5, idle T+6.
      send(5'd3, 16'h0010);
      step();
      chk("t1_strobe", mem_rd_en, 1'b1);
      chk("t1_addr", mem_addr, 16'h0010);
      step();
      chk("t1_ret_t3", data_return[39], 1'b0);
      step();
      chk("t1_ret_t4", data_return[39], 1'b0);
      step();
      chk("t1_ret_t5", data_return, {1'b1, 5'd3, 32'h0000_DEAD, 2'b00});
      step();
      chk("t1_ret_t6", data_return[39], 1'b0);
      chk("t1_idle_t6", idle, 1'b1);

      // Fill under halt, fifth request held, then release.
      halt = 1'b1;
      for (int i = 1; i <= 4; i++) send(5'(i), 16'h0100 + 16'(i));
      chk("t2_pending_full", pending_count, 3'd4);
      chk("t2_ready_low", req_ready, 1'b0);
      req_valid = 1'b1; req_id = 5'd5; req_addr = 16'h0105;
      step();
      chk("t2_still_full", pending_count, 3'd4);
      halt = 1'b0;
      send(5'd5, 16'h0105);
      wait_idle();
      chk("t2_consecutive", run_len, 5);
      chk("t2_sb_empty", sb.size(), 0);

      // Simultaneous push/pop at count 2, wrapping pointers.
      halt = 1'b1;
      send(5'd10, 16'h0200);
      send(5'd11, 16'h0201);
      chk("t3_count2", pending_count, 3'd2);
      halt = 1'b0;
      for (int i = 0; i < 11; i++) begin
         send(5'(12 + i), 16'h0300 + 16'(i));
         chk("t3_count_hold", pending_count, 3'd2);
      end
      wait_idle();
      chk("t3_sb_empty", sb.size(), 0);

      // Halt with two in flight and two queued.
      halt = 1'b1;
      for (int i = 0; i < 4; i++) send(5'(24 + i), 16'h0400 + 16'(i));
      base = ret_total;
      halt = 1'b0;
      step();
      step();
      halt = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         chk("t4_halted_no_strobe", mem_rd_en, 1'b0);
      end
      chk("t4_inflight_returned", ret_total - base, 2);
      chk("t4_queued", pending_count, 3'd2);
      halt = 1'b0;
      wait_idle();
      chk("t4_all_returned", ret_total - base, 4);

      // Asynchronous reset mid-cycle with reads in flight.
      send(5'd1, 16'h0500);
      send(5'd2, 16'h0501);
      send(5'd3, 16'h0502);
      step();
      base = ret_total;
      #3;
      rst_n = 1'b0;
      #1;
      chk("t5_mem_rd_en", mem_rd_en, 1'b0);
      chk("t5_mem_addr", mem_addr, 16'h0);
      chk("t5_data_return", data_return, 40'h0);
      chk("t5_req_ready", req_ready, 1'b1);
      chk("t5_pending", pending_count, 3'd0);
      chk("t5_idle", idle, 1'b1);
      sb.delete();
      step();
      rst_n = 1'b1;
      repeat (10) step();
      chk("t5_no_returns", ret_total - base, 0);

      // Duplicate ids return in issue order with their own data.
      base = ret_total;
      send(5'd7, 16'h0020);
      send(5'd7, 16'h0021);
      wait_idle();
      chk("t6_two_returns", ret_total - base, 2);
      chk("t6_sb_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
